// File: rtl/mips32_prog_loader_if.sv
// mips32_prog_loader_if: byte-stream input, instruction-memory write port and status bundle for the program loader
//   start/in_valid/in_data : stream side, driven by the host
//   in_ready               : loader accepts a byte this cycle
//   mem_we/mem_addr/mem_wdata : single word write port into the core's instruction memory
//   cpu_hold/load_done/load_err/words_loaded : loader status
interface mips32_prog_loader_if #(parameter int ADDR_W = 10);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;
  modport master (output start, in_valid, in_data,
                  input in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, words_loaded);
  modport slave  (input start, in_valid, in_data,
                  output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, words_loaded);
endinterface

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: framed byte-serial loader writing 32-bit big-endian words into the pipe_MIPS32 instruction memory
//   clk1 : clock, rst : asynchronous active-high reset
//   bus  : mips32_prog_loader_if slave (stream in, memory write port, hold/done/err/words_loaded status)
//   Frame: MAGIC, N[15:8], N[7:0], 4N payload bytes MSB first, XOR checksum of the payload.
//   Optional: define LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYC idle cycles.
module mips32_prog_loader #(
  parameter int         ADDR_W      = 10,
  parameter int         BASE_ADDR   = 0,
  parameter int         MAX_WORDS   = 1024,
  parameter logic [7:0] MAGIC       = 8'hA5,
  parameter int         TIMEOUT_CYC = 4096
) (
  input logic                clk1,
  input logic                rst,
  mips32_prog_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CHK, DONE, ERR} state_t;
  state_t            r_state, w_next;
  logic [15:0]       r_n;
  logic [1:0]        r_lane;
  logic [23:0]       r_shift;
  logic [7:0]        r_chk;
  logic [ADDR_W:0]   r_words;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              w_acc, w_last, w_to, w_rearm;
  logic [15:0]       w_n_full;
  assign w_acc    = bus.in_valid && bus.in_ready;
  assign w_n_full = {r_n[7:0], bus.in_data};
  assign w_last   = 16'(r_words) + 16'd1 == r_n;
  assign w_rearm  = (r_state == DONE || r_state == ERR) && bus.start;
`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to;
  logic            w_in_frame;
  assign w_in_frame = r_state inside {CNT_HI, CNT_LO, DATA, CHK};
  always_ff @(posedge clk1 or posedge rst)
    if (rst) r_to <= '0;
    else     r_to <= (w_acc || !w_in_frame) ? '0 : r_to + 1'b1;
  assign w_to = w_in_frame && !w_acc && r_to == TO_W'(TIMEOUT_CYC - 1);
`else
  assign w_to = TIMEOUT_CYC < 0;
`endif
  always_ff @(posedge clk1 or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = (w_acc && bus.in_data == MAGIC) ? CNT_HI : IDLE;
      CNT_HI:    w_next = w_acc ? CNT_LO : CNT_HI;
      CNT_LO:    w_next = !w_acc ? CNT_LO : (w_n_full == 16'd0) ? CHK : (32'(w_n_full) > MAX_WORDS) ? ERR : DATA;
      DATA:      w_next = (w_acc && r_lane == 2'd3 && w_last) ? CHK : DATA;
      CHK:       w_next = !w_acc ? CHK : (bus.in_data == r_chk) ? DONE : ERR;
      DONE, ERR: w_next = bus.start ? IDLE : r_state;
      default:   w_next = IDLE;
    endcase
    if (w_to) w_next = ERR;
  end
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      r_n     <= '0;
      r_lane  <= '0;
      r_shift <= '0;
      r_chk   <= '0;
      r_words <= '0;
      r_we    <= 1'b0;
      r_addr  <= ADDR_W'(BASE_ADDR);
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_acc && (r_state == CNT_HI || r_state == CNT_LO)) r_n <= w_n_full;
      if (w_acc && r_state == DATA) begin
        r_shift <= {r_shift[15:0], bus.in_data};
        r_chk   <= r_chk ^ bus.in_data;
        r_lane  <= r_lane + 2'd1;
        if (r_lane == 2'd3) begin
          r_we    <= 1'b1;
          r_addr  <= ADDR_W'(BASE_ADDR) + r_words[ADDR_W-1:0];
          r_wdata <= {r_shift, bus.in_data};
          r_words <= r_words + 1'b1;
        end
      end
      if (w_rearm) begin
        r_lane  <= '0;
        r_chk   <= '0;
        r_words <= '0;
      end
    end
  assign bus.in_ready     = !(r_state == DONE || r_state == ERR);
  assign bus.mem_we       = r_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.cpu_hold     = r_state != DONE;
  assign bus.load_done    = r_state == DONE;
  assign bus.load_err     = r_state == ERR;
  assign bus.words_loaded = r_words;
endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb_mips32_prog_loader: directed self-checking bench for mips32_prog_loader
module tb_mips32_prog_loader;
  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  int checks = 0, errors = 0, n_writes = 0;
  always #5 clk1 = ~clk1;
  mips32_prog_loader_if #(.ADDR_W(10)) bus();
  mips32_prog_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(1024), .MAGIC(8'hA5), .TIMEOUT_CYC(16))
    dut (.clk1(clk1), .rst(rst), .bus(bus));
  always @(posedge clk1) if (bus.mem_we === 1'b1) n_writes++;

  task automatic send(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk1); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start;
    bus.start = 1'b1;
    @(posedge clk1); #1;
    bus.start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %b want 1", tag, bus.in_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL %s mem_we: got %b want 0", tag, bus.mem_we); end
    checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL %s cpu_hold: got %b want 1", tag, bus.cpu_hold); end
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL %s load_done: got %b want 0", tag, bus.load_done); end
    checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL %s load_err: got %b want 0", tag, bus.load_err); end
    checks++; if (bus.words_loaded !== 11'd0) begin errors++; $display("FAIL %s words_loaded: got %0d want 0", tag, bus.words_loaded); end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk1); #1;
    check_idle("reset");
    checks++; if (bus.mem_addr !== 10'd0) begin errors++; $display("FAIL reset mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset mem_wdata: got %h want 0", bus.mem_wdata); end
    rst = 1'b0;
  endtask

  // Payload XOR: 28^01^00^0A^FC^00^00^00 = DF
  task automatic test_good_frame;
    int w0 = n_writes;
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h28); send(8'h01); send(8'h00); send(8'h0A);
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL good w0 mem_we: got %b want 1", bus.mem_we); end
    checks++; if (bus.mem_addr !== 10'd0) begin errors++; $display("FAIL good w0 mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h2801000A) begin errors++; $display("FAIL good w0 mem_wdata: got %h want 2801000a", bus.mem_wdata); end
    checks++; if (bus.words_loaded !== 11'd1) begin errors++; $display("FAIL good w0 words_loaded: got %0d want 1", bus.words_loaded); end
    send(8'hFC);
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL good mid mem_we: got %b want 0", bus.mem_we); end
    send(8'h00); send(8'h00); send(8'h00);
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL good w1 mem_we: got %b want 1", bus.mem_we); end
    checks++; if (bus.mem_addr !== 10'd1) begin errors++; $display("FAIL good w1 mem_addr: got %h want 1", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'hFC000000) begin errors++; $display("FAIL good w1 mem_wdata: got %h want fc000000", bus.mem_wdata); end
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL good early done: got %b want 0", bus.load_done); end
    send(8'hDF);
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL good load_done: got %b want 1", bus.load_done); end
    checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL good cpu_hold: got %b want 0", bus.cpu_hold); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL good in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.words_loaded !== 11'd2) begin errors++; $display("FAIL good words_loaded: got %0d want 2", bus.words_loaded); end
    checks++; if (n_writes - w0 !== 2) begin errors++; $display("FAIL good writes: got %0d want 2", n_writes - w0); end
    pulse_start;
    check_idle("good rearm");
  endtask

  task automatic test_bad_chk;
    int w0 = n_writes;
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h28); send(8'h01); send(8'h00); send(8'h0A);
    send(8'hFC); send(8'h00); send(8'h00); send(8'h00);
    send(8'h00);
    checks++; if (bus.load_err !== 1'b1) begin errors++; $display("FAIL badchk load_err: got %b want 1", bus.load_err); end
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL badchk load_done: got %b want 0", bus.load_done); end
    checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL badchk cpu_hold: got %b want 1", bus.cpu_hold); end
    checks++; if (n_writes - w0 !== 2) begin errors++; $display("FAIL badchk writes: got %0d want 2", n_writes - w0); end
    pulse_start;
    check_idle("badchk rearm");
  endtask

  task automatic test_drop_zero;
    int w0 = n_writes;
    send(8'h00); send(8'h13);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL drop in_ready: got %b want 1", bus.in_ready); end
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL zero load_done: got %b want 1", bus.load_done); end
    checks++; if (n_writes - w0 !== 0) begin errors++; $display("FAIL zero writes: got %0d want 0", n_writes - w0); end
    pulse_start;
    check_idle("zero rearm");
  endtask

  task automatic test_too_many;
    int w0 = n_writes;
    send(8'hA5); send(8'h04); send(8'h01);
    checks++; if (bus.load_err !== 1'b1) begin errors++; $display("FAIL toomany load_err: got %b want 1", bus.load_err); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL toomany in_ready: got %b want 0", bus.in_ready); end
    checks++; if (n_writes - w0 !== 0) begin errors++; $display("FAIL toomany writes: got %0d want 0", n_writes - w0); end
    pulse_start;
    check_idle("toomany rearm");
  endtask

  // Reload payload XOR: 12^34^56^78 = 08; start during DATA must be ignored
  task automatic test_rst_mid;
    int w0 = n_writes;
    send(8'hA5); send(8'h00); send(8'h01); send(8'h28); send(8'h01);
    #2 rst = 1'b1;
    #1;
    check_idle("rstmid");
    checks++; if (bus.mem_addr !== 10'd0) begin errors++; $display("FAIL rstmid mem_addr: got %h want 0", bus.mem_addr); end
    @(posedge clk1); #1;
    checks++; if (n_writes - w0 !== 0) begin errors++; $display("FAIL rstmid writes: got %0d want 0", n_writes - w0); end
    rst = 1'b0;
    send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
    bus.start = 1'b1;
    send(8'h34);
    bus.start = 1'b0;
    send(8'h56); send(8'h78);
    checks++; if (bus.mem_wdata !== 32'h12345678) begin errors++; $display("FAIL reload mem_wdata: got %h want 12345678", bus.mem_wdata); end
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL reload mem_we: got %b want 1", bus.mem_we); end
    send(8'h08);
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL reload load_done: got %b want 1", bus.load_done); end
    checks++; if (bus.words_loaded !== 11'd1) begin errors++; $display("FAIL reload words_loaded: got %0d want 1", bus.words_loaded); end
    pulse_start;
  endtask

`ifdef LOADER_TIMEOUT_EN
  task automatic test_timeout;
    send(8'hA5); send(8'h00); send(8'h01);
    repeat (15) @(posedge clk1);
    #1;
    checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL timeout early load_err: got %b want 0", bus.load_err); end
    @(posedge clk1); #1;
    checks++; if (bus.load_err !== 1'b1) begin errors++; $display("FAIL timeout load_err: got %b want 1", bus.load_err); end
    pulse_start;
  endtask
`endif

  initial begin
    test_reset;
    test_good_frame;
    test_bad_chk;
    test_drop_zero;
    test_too_many;
    test_rst_mid;
`ifdef LOADER_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
